// File: rtl/pipe_hazard_ctrl.sv
// LEGv8 5-stage pipeline hazard sequencer: load-use stalls, taken-branch flushes, data-memory waits.
// Optional HAZ_PERF_CNT_EN macro enables the saturating StallCount/FlushCount performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT       = 15,
  parameter int unsigned CNT_W             = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       ID_Rn,
  input  logic [4:0]       ID_Rm,
  input  logic             ID_UsesRm,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_Rd,
  input  logic             MEM_Branch,
  input  logic             MEM_Zero,
  input  logic             MEM_MemRead,
  input  logic             MEM_MemWrite,
  input  logic             DMemReady,
  output logic             DMemReq,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Write,
  output logic             EX_MEM_Flush,
  output logic             MEM_WB_Bubble,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LSTALL = 2'd1,
    ST_WAIT   = 2'd2
  } state_e;

  localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  state_e     ret_q, ret_d;
  logic [2:0] stall_q, stall_d;
  logic [7:0] wait_q, wait_d;
  logic       tmo_q, tmo_d;

  logic mem_acc, mem_ready, mem_stall, taken, hazard;

  assign mem_acc   = MEM_MemRead | MEM_MemWrite;
  assign mem_ready = mem_acc & DMemReady;
  assign mem_stall = mem_acc & ~DMemReady;
  assign taken     = MEM_Branch & MEM_Zero;
  assign hazard    = EX_MemRead && (EX_Rd != 5'd31) &&
                     ((EX_Rd == ID_Rn) || (ID_UsesRm && (EX_Rd == ID_Rm)));

  assign DMemReq    = mem_acc & reset_n;
  assign MemTimeout = tmo_q;

  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    stall_d       = stall_q;
    wait_d        = wait_q;
    tmo_d         = tmo_q;
    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Bubble  = 1'b0;
    ID_EX_Flush   = 1'b0;
    EX_MEM_Write  = 1'b1;
    EX_MEM_Flush  = 1'b0;
    MEM_WB_Bubble = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          PCWrite       = 1'b0;
          IF_ID_Write   = 1'b0;
          EX_MEM_Write  = 1'b0;
          MEM_WB_Bubble = 1'b1;
          state_d       = ST_WAIT;
          ret_d         = ST_RUN;
          wait_d        = 8'd1;
        end else if (taken) begin
          IF_ID_Flush  = 1'b1;
          ID_EX_Flush  = 1'b1;
          EX_MEM_Flush = 1'b1;
        end else if (hazard) begin
          PCWrite      = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_d = ST_LSTALL;
            stall_d = STALL_INIT;
          end
        end
      end

      ST_LSTALL: begin
        if (mem_stall) begin
          PCWrite       = 1'b0;
          IF_ID_Write   = 1'b0;
          EX_MEM_Write  = 1'b0;
          MEM_WB_Bubble = 1'b1;
          state_d       = ST_WAIT;
          ret_d         = ST_LSTALL;
          wait_d        = 8'd1;
        end else begin
          PCWrite      = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
          stall_d      = stall_q - 3'd1;
          if (stall_q <= 3'd1) state_d = ST_RUN;
        end
      end

      ST_WAIT: begin
        // Timeout releases exactly like a ready; ready on the limit cycle wins and sets no error.
        if (mem_ready || (wait_q >= WAIT_LIMIT)) begin
          wait_d  = '0;
          if (!mem_ready) tmo_d = 1'b1;
          state_d = ((ret_q == ST_LSTALL) && (stall_q != '0)) ? ST_LSTALL : ST_RUN;
        end else begin
          PCWrite       = 1'b0;
          IF_ID_Write   = 1'b0;
          EX_MEM_Write  = 1'b0;
          MEM_WB_Bubble = 1'b1;
          wait_d        = wait_q + 8'd1;
        end
      end

      default: state_d = ST_RUN;
    endcase

    if (!reset_n) begin
      PCWrite       = 1'b0;
      IF_ID_Write   = 1'b0;
      IF_ID_Flush   = 1'b0;
      ID_EX_Bubble  = 1'b0;
      ID_EX_Flush   = 1'b0;
      EX_MEM_Write  = 1'b0;
      EX_MEM_Flush  = 1'b0;
      MEM_WB_Bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      ret_q   <= ST_RUN;
      stall_q <= '0;
      wait_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      stall_q <= stall_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (ID_EX_Bubble && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (IF_ID_Flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`else
  assign StallCount = '0;
  assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one instance with a single load-use bubble, one with three.
module tb_pipe_hazard_ctrl;

`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {DMemReq, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, ID_EX_Flush, EX_MEM_Write, EX_MEM_Flush, MEM_WB_Bubble}
  localparam logic [8:0] DEF = 9'b0_1_1_0_0_0_1_0_0;
  localparam logic [8:0] REL = 9'b1_1_1_0_0_0_1_0_0;
  localparam logic [8:0] FRZ = 9'b1_0_0_0_0_0_0_0_1;
  localparam logic [8:0] RST = 9'b0_0_0_0_0_0_0_0_1;
  localparam logic [8:0] STL = 9'b0_0_0_0_1_0_1_0_0;
  localparam logic [8:0] FLS = 9'b0_1_1_1_0_1_1_1_0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [4:0] ID_Rn, ID_Rm, EX_Rd;
  logic       ID_UsesRm, EX_MemRead, MEM_Branch, MEM_Zero, MEM_MemRead, MEM_MemWrite, DMemReady;

  logic        a_DMemReq, a_PCWrite, a_IF_ID_Write, a_IF_ID_Flush, a_ID_EX_Bubble, a_ID_EX_Flush;
  logic        a_EX_MEM_Write, a_EX_MEM_Flush, a_MEM_WB_Bubble, a_MemTimeout;
  logic [15:0] a_StallCount, a_FlushCount;
  logic        b_DMemReq, b_PCWrite, b_IF_ID_Write, b_IF_ID_Flush, b_ID_EX_Bubble, b_ID_EX_Flush;
  logic        b_EX_MEM_Write, b_EX_MEM_Flush, b_MEM_WB_Bubble, b_MemTimeout;
  logic [15:0] b_StallCount, b_FlushCount;

  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(15), .CNT_W(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_UsesRm(ID_UsesRm),
    .EX_MemRead(EX_MemRead), .EX_Rd(EX_Rd), .MEM_Branch(MEM_Branch), .MEM_Zero(MEM_Zero),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .DMemReady(DMemReady),
    .DMemReq(a_DMemReq), .PCWrite(a_PCWrite), .IF_ID_Write(a_IF_ID_Write), .IF_ID_Flush(a_IF_ID_Flush),
    .ID_EX_Bubble(a_ID_EX_Bubble), .ID_EX_Flush(a_ID_EX_Flush), .EX_MEM_Write(a_EX_MEM_Write),
    .EX_MEM_Flush(a_EX_MEM_Flush), .MEM_WB_Bubble(a_MEM_WB_Bubble), .MemTimeout(a_MemTimeout),
    .StallCount(a_StallCount), .FlushCount(a_FlushCount)
  );

  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(15), .CNT_W(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_UsesRm(ID_UsesRm),
    .EX_MemRead(EX_MemRead), .EX_Rd(EX_Rd), .MEM_Branch(MEM_Branch), .MEM_Zero(MEM_Zero),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .DMemReady(DMemReady),
    .DMemReq(b_DMemReq), .PCWrite(b_PCWrite), .IF_ID_Write(b_IF_ID_Write), .IF_ID_Flush(b_IF_ID_Flush),
    .ID_EX_Bubble(b_ID_EX_Bubble), .ID_EX_Flush(b_ID_EX_Flush), .EX_MEM_Write(b_EX_MEM_Write),
    .EX_MEM_Flush(b_EX_MEM_Flush), .MEM_WB_Bubble(b_MEM_WB_Bubble), .MemTimeout(b_MemTimeout),
    .StallCount(b_StallCount), .FlushCount(b_FlushCount)
  );

  logic [8:0] a_ctl, b_ctl;
  assign a_ctl = {a_DMemReq, a_PCWrite, a_IF_ID_Write, a_IF_ID_Flush, a_ID_EX_Bubble,
                  a_ID_EX_Flush, a_EX_MEM_Write, a_EX_MEM_Flush, a_MEM_WB_Bubble};
  assign b_ctl = {b_DMemReq, b_PCWrite, b_IF_ID_Write, b_IF_ID_Flush, b_ID_EX_Bubble,
                  b_ID_EX_Flush, b_EX_MEM_Write, b_EX_MEM_Flush, b_MEM_WB_Bubble};

  typedef struct {
    string       tag;
    int unsigned inst;
    logic [8:0]  ctl;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected control word is queued with the stimulus and retired mid-cycle.
  task automatic cyc(input string tag, input int unsigned inst, input logic [8:0] ctl);
    exp_t e;
    sb.push_back('{tag: tag, inst: inst, ctl: ctl});
    @(negedge clk);
    e = sb.pop_front();
    check(e.tag, {23'b0, (e.inst == 3) ? b_ctl : a_ctl}, {23'b0, e.ctl});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ID_Rn = 5'd0; ID_Rm = 5'd0; ID_UsesRm = 1'b0; EX_MemRead = 1'b0; EX_Rd = 5'd0;
    MEM_Branch = 1'b0; MEM_Zero = 1'b0; MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; DMemReady = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    idle();
    cyc("reset_ctl", 1, RST);
    check("reset_tmo", {31'b0, a_MemTimeout}, 32'd0);
    check("reset_stallcnt", {16'b0, a_StallCount}, 32'd0);
    reset_n = 1'b1;
    cyc("idle", 1, DEF);

    // Load-use on Rn
    EX_MemRead = 1'b1; EX_Rd = 5'd2; ID_Rn = 5'd2;
    cyc("lu_rn", 1, STL);
    EX_MemRead = 1'b0;
    cyc("lu_after", 1, DEF);
    check("stallcnt_1", {16'b0, a_StallCount}, PERF ? 32'd1 : 32'd0);

    // X31 never hazards; Rm only when used
    EX_MemRead = 1'b1; EX_Rd = 5'd31; ID_Rn = 5'd31;
    cyc("lu_x31", 1, DEF);
    EX_Rd = 5'd3; ID_Rn = 5'd0; ID_Rm = 5'd3; ID_UsesRm = 1'b0;
    cyc("lu_rm_unused", 1, DEF);
    ID_UsesRm = 1'b1;
    cyc("lu_rm_used", 1, STL);
    idle();
    cyc("idle2", 1, DEF);
    check("stallcnt_2", {16'b0, a_StallCount}, PERF ? 32'd2 : 32'd0);

    // Taken branch flush, untaken branch, taken overriding hazard
    MEM_Branch = 1'b1; MEM_Zero = 1'b1;
    cyc("taken", 1, FLS);
    MEM_Zero = 1'b0;
    cyc("untaken", 1, DEF);
    check("flushcnt_1", {16'b0, a_FlushCount}, PERF ? 32'd1 : 32'd0);
    MEM_Zero = 1'b1; EX_MemRead = 1'b1; EX_Rd = 5'd4; ID_Rn = 5'd4;
    cyc("taken_over_hazard", 1, FLS);
    idle();
    cyc("idle3", 1, DEF);
    check("flushcnt_2", {16'b0, a_FlushCount}, PERF ? 32'd2 : 32'd0);
    check("stallcnt_noinc", {16'b0, a_StallCount}, PERF ? 32'd2 : 32'd0);

    // STUR with three wait cycles
    MEM_MemWrite = 1'b1;
    for (int i = 0; i < 3; i++) cyc("stur_wait", 1, FRZ);
    DMemReady = 1'b1;
    cyc("stur_release", 1, REL);
    idle();
    cyc("idle4", 1, DEF);
    check("stur_tmo", {31'b0, a_MemTimeout}, 32'd0);

    // Immediate ready; taken deferred while memory stalls
    MEM_MemRead = 1'b1; DMemReady = 1'b1;
    cyc("ldur_ready", 1, REL);
    DMemReady = 1'b0; MEM_Branch = 1'b1; MEM_Zero = 1'b1;
    cyc("taken_deferred", 1, FRZ);
    MEM_Branch = 1'b0; MEM_Zero = 1'b0; DMemReady = 1'b1;
    cyc("deferred_release", 1, REL);
    idle();
    cyc("idle5", 1, DEF);
    check("flushcnt_deferred", {16'b0, a_FlushCount}, PERF ? 32'd2 : 32'd0);

    // Timeout: 15 frozen cycles, forced release, sticky flag
    MEM_MemRead = 1'b1;
    for (int i = 0; i < 15; i++) cyc("tmo_wait", 1, FRZ);
    cyc("tmo_release", 1, REL);
    idle();
    cyc("idle6", 1, DEF);
    check("tmo_set", {31'b0, a_MemTimeout}, 32'd1);
    MEM_MemRead = 1'b1; DMemReady = 1'b1;
    cyc("post_tmo_ready", 1, REL);
    idle();
    cyc("idle7", 1, DEF);
    check("tmo_sticky", {31'b0, a_MemTimeout}, 32'd1);
    reset_n = 1'b0;
    cyc("reset_pulse", 1, RST);
    reset_n = 1'b1;
    cyc("idle8", 3, DEF);
    check("tmo_cleared", {31'b0, a_MemTimeout}, 32'd0);
    check("stallcnt_cleared", {16'b0, a_StallCount}, 32'd0);

    // Three-cycle load-use with a two-cycle memory wait in the middle
    EX_MemRead = 1'b1; EX_Rd = 5'd5; ID_Rn = 5'd5;
    cyc("ls3_first", 3, STL);
    EX_MemRead = 1'b0; MEM_MemWrite = 1'b1; DMemReady = 1'b0;
    cyc("ls3_wait0", 3, FRZ);
    cyc("ls3_wait1", 3, FRZ);
    DMemReady = 1'b1;
    cyc("ls3_release", 3, REL);
    idle();
    cyc("ls3_resume0", 3, STL);
    cyc("ls3_resume1", 3, STL);
    cyc("ls3_done", 3, DEF);
    check("ls3_stallcnt", {16'b0, b_StallCount}, PERF ? 32'd3 : 32'd0);

    // Reset while waiting inside a load-use stall
    EX_MemRead = 1'b1; EX_Rd = 5'd6; ID_Rn = 5'd6;
    cyc("ls3b_first", 3, STL);
    EX_MemRead = 1'b0; MEM_MemWrite = 1'b1;
    cyc("ls3b_wait", 3, FRZ);
    reset_n = 1'b0;
    cyc("ls3b_reset", 3, RST);
    reset_n = 1'b1;
    idle();
    cyc("ls3b_run0", 3, DEF);
    cyc("ls3b_run1", 3, DEF);
    check("ls3b_stallcnt", {16'b0, b_StallCount}, 32'd0);
    check("ls3b_tmo", {31'b0, b_MemTimeout}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
